// File: rtl/sketch_pkg.sv
// rtl/sketch_pkg.sv - shared widths, types and FSM state for the count-min sketch row
package sketch_pkg;
  localparam int SKETCH_INDEX_WIDTH = 10;
  localparam int SKETCH_COUNT_WIDTH = 32;

  typedef logic [SKETCH_INDEX_WIDTH-1:0] sketch_idx_t;
  typedef logic [SKETCH_COUNT_WIDTH-1:0] sketch_cnt_t;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } sketch_row_state_e;
endpackage

// File: rtl/sketch_row_ram.sv
// rtl/sketch_row_ram.sv - simple dual-port row RAM, 1-cycle synchronous read, read-first
module sketch_row_ram #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clock,
  input  logic                  i_we,
  input  logic [ADDR_WIDTH-1:0] i_waddr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic [ADDR_WIDTH-1:0] i_raddr,
  output logic [DATA_WIDTH-1:0] o_rdata
);
  logic [DATA_WIDTH-1:0] r_mem [2**ADDR_WIDTH];

  // Contents are never reset; the row clear sweep zeroes them.
  always_ff @(posedge clock) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    o_rdata <= r_mem[i_raddr];
  end
endmodule

// File: rtl/sketch_row_counter.sv
// rtl/sketch_row_counter.sv - count-min sketch row: pipelined increment with forwarding, query port, clear sweep
// Define SKETCH_SATURATE_EN to saturate counters at all-ones instead of wrapping.
module sketch_row_counter
  import sketch_pkg::*;
#(
  parameter int INDEX_WIDTH = SKETCH_INDEX_WIDTH,
  parameter int COUNT_WIDTH = SKETCH_COUNT_WIDTH
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   upd_valid,
  input  logic [INDEX_WIDTH-1:0] upd_index,
  output logic                   upd_ready,
  input  logic                   qry_valid,
  input  logic [INDEX_WIDTH-1:0] qry_index,
  output logic                   qry_ready,
  output logic                   qry_resp_valid,
  output logic [COUNT_WIDTH-1:0] qry_resp_data,
  input  logic                   clear_start,
  output logic                   clear_busy
);
  sketch_row_state_e      r_state, w_state_nxt;
  logic [INDEX_WIDTH-1:0] r_sweep_addr, w_sweep_addr_nxt;

  logic                   w_run, w_upd_acc, w_qry_acc, w_s1_write;
  logic                   r_s1_valid, r_q1_valid, r_lw_valid, r_qry_resp_valid;
  logic [INDEX_WIDTH-1:0] r_s1_index, r_q1_index, r_lw_index;
  logic [COUNT_WIDTH-1:0] r_lw_value, r_qry_resp_data;
  logic [COUNT_WIDTH-1:0] w_rd_data, w_s1_src, w_s1_new, w_q_src;
  logic                   w_ram_we;
  logic [INDEX_WIDTH-1:0] w_ram_waddr, w_ram_raddr;
  logic [COUNT_WIDTH-1:0] w_ram_wdata;

  assign w_run          = (r_state == ST_RUN) && !reset;
  assign upd_ready      = w_run;
  assign qry_ready      = w_run && !upd_valid;
  assign clear_busy     = !w_run;
  assign w_upd_acc      = upd_valid && upd_ready;
  assign w_qry_acc      = qry_valid && qry_ready;
  assign qry_resp_valid = r_qry_resp_valid;
  assign qry_resp_data  = r_qry_resp_data;

  always_comb begin
    w_state_nxt      = r_state;
    w_sweep_addr_nxt = r_sweep_addr;
    case (r_state)
      ST_CLEAR: begin
        w_sweep_addr_nxt = r_sweep_addr + INDEX_WIDTH'(1);
        if (r_sweep_addr == {INDEX_WIDTH{1'b1}}) w_state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (clear_start) begin
          w_state_nxt      = ST_CLEAR;
          w_sweep_addr_nxt = '0;
        end
      end
      default: w_state_nxt = ST_CLEAR;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state      <= ST_CLEAR;
      r_sweep_addr <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_sweep_addr <= w_sweep_addr_nxt;
    end
  end

  // Last-write register wins over RAM data: the RAM read was issued before that write landed.
  assign w_s1_src = (r_lw_valid && (r_lw_index == r_s1_index)) ? r_lw_value : w_rd_data;

`ifdef SKETCH_SATURATE_EN
  assign w_s1_new = (w_s1_src == {COUNT_WIDTH{1'b1}}) ? w_s1_src : w_s1_src + COUNT_WIDTH'(1);
`else
  assign w_s1_new = w_s1_src + COUNT_WIDTH'(1);
`endif

  assign w_s1_write = r_s1_valid && (r_state == ST_RUN) && !reset;

  assign w_q_src = (w_s1_write && (r_s1_index == r_q1_index))   ? w_s1_new   :
                   (r_lw_valid && (r_lw_index == r_q1_index))   ? r_lw_value :
                                                                  w_rd_data;

  // An update landing in S1 during the first sweep cycle is dropped: the sweep zeroes its bucket anyway.
  always_comb begin
    w_ram_we    = 1'b0;
    w_ram_waddr = r_s1_index;
    w_ram_wdata = w_s1_new;
    if (!reset) begin
      if (r_state == ST_CLEAR) begin
        w_ram_we    = 1'b1;
        w_ram_waddr = r_sweep_addr;
        w_ram_wdata = '0;
      end else begin
        w_ram_we = r_s1_valid;
      end
    end
  end

  assign w_ram_raddr = w_upd_acc ? upd_index : qry_index;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_s1_valid       <= 1'b0;
      r_q1_valid       <= 1'b0;
      r_lw_valid       <= 1'b0;
      r_qry_resp_valid <= 1'b0;
      r_qry_resp_data  <= '0;
    end else begin
      r_s1_valid       <= w_upd_acc;
      r_q1_valid       <= w_qry_acc;
      r_qry_resp_valid <= r_q1_valid;
      if (r_q1_valid) r_qry_resp_data <= w_q_src;
      if (r_state == ST_CLEAR) r_lw_valid <= 1'b0;
      else if (r_s1_valid)     r_lw_valid <= 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    r_s1_index <= upd_index;
    r_q1_index <= qry_index;
    if (w_s1_write) begin
      r_lw_index <= r_s1_index;
      r_lw_value <= w_s1_new;
    end
  end

  sketch_row_ram #(
    .ADDR_WIDTH (INDEX_WIDTH),
    .DATA_WIDTH (COUNT_WIDTH)
  ) u_ram (
    .clock   (clock),
    .i_we    (w_ram_we),
    .i_waddr (w_ram_waddr),
    .i_wdata (w_ram_wdata),
    .i_raddr (w_ram_raddr),
    .o_rdata (w_rd_data)
  );
endmodule

// File: tb/tb_sketch_row_counter.sv
// tb/tb_sketch_row_counter.sv - scoreboard bench for sketch_row_counter (default and 4-bit count instances)
module tb_sketch_row_counter;
  localparam int IW = 10;
  localparam int CW = 32;
`ifdef SKETCH_SATURATE_EN
  localparam int SAT_EXP = 15;
`else
  localparam int SAT_EXP = 1;
`endif

  typedef struct {
    logic [31:0] data;
    int          cyc;
  } exp_t;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic          reset = 1'b1;
  logic          upd_valid = 1'b0, qry_valid = 1'b0, clear_start = 1'b0;
  logic [IW-1:0] upd_index = '0, qry_index = '0;
  logic          upd_ready, qry_ready, qry_resp_valid, clear_busy;
  logic [CW-1:0] qry_resp_data;

  logic          u4_valid = 1'b0, q4_valid = 1'b0, c4_start = 1'b0;
  logic [IW-1:0] u4_index = '0, q4_index = '0;
  logic          u4_ready, q4_ready, q4_resp_valid, c4_busy;
  logic [3:0]    q4_resp_data;

  sketch_row_counter #(.INDEX_WIDTH(IW), .COUNT_WIDTH(CW)) dut (
    .clock(clock), .reset(reset),
    .upd_valid(upd_valid), .upd_index(upd_index), .upd_ready(upd_ready),
    .qry_valid(qry_valid), .qry_index(qry_index), .qry_ready(qry_ready),
    .qry_resp_valid(qry_resp_valid), .qry_resp_data(qry_resp_data),
    .clear_start(clear_start), .clear_busy(clear_busy)
  );

  sketch_row_counter #(.INDEX_WIDTH(IW), .COUNT_WIDTH(4)) dut4 (
    .clock(clock), .reset(reset),
    .upd_valid(u4_valid), .upd_index(u4_index), .upd_ready(u4_ready),
    .qry_valid(q4_valid), .qry_index(q4_index), .qry_ready(q4_ready),
    .qry_resp_valid(q4_resp_valid), .qry_resp_data(q4_resp_data),
    .clear_start(c4_start), .clear_busy(c4_busy)
  );

  int          n_checks = 0, n_pass = 0;
  int          cyc = 0;
  int unsigned model [1024];
  exp_t        sb[$], sb4[$];
  exp_t        mon_e, mon_e4;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  always @(negedge clock) begin
    if (qry_resp_valid) begin
      if (sb.size() == 0) begin
        n_checks++;
        $display("FAIL resp_unexpected: got response %0d with nothing pending (cycle %0d)", qry_resp_data, cyc);
      end else begin
        mon_e = sb.pop_front();
        check("resp_data", qry_resp_data, mon_e.data);
        check("resp_cycle", cyc, mon_e.cyc);
      end
    end
  end

  always @(negedge clock) begin
    if (q4_resp_valid) begin
      if (sb4.size() == 0) begin
        n_checks++;
        $display("FAIL resp4_unexpected: got response %0d with nothing pending (cycle %0d)", q4_resp_data, cyc);
      end else begin
        mon_e4 = sb4.pop_front();
        check("resp4_data", q4_resp_data, mon_e4.data);
        check("resp4_cycle", cyc, mon_e4.cyc);
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_model();
    for (int i = 0; i < 1024; i++) model[i] = 0;
  endtask

  task automatic upd(input int idx);
    upd_valid = 1'b1;
    upd_index = IW'(idx);
    @(negedge clock);
    check("upd_ready", upd_ready, 1);
    model[idx]++;
    tick();
    upd_valid = 1'b0;
  endtask

  task automatic qry(input int idx);
    int n = 0;
    qry_valid = 1'b1;
    qry_index = IW'(idx);
    @(negedge clock);
    while (!qry_ready && n < 50) begin
      tick();
      @(negedge clock);
      n++;
    end
    check("qry_accept", qry_ready, 1);
    if (qry_ready) sb.push_back('{model[idx], cyc + 2});
    tick();
    qry_valid = 1'b0;
  endtask

  task automatic count_busy(input string name);
    int n = 0;
    @(negedge clock);
    while (clear_busy && n < 3000) begin
      n++;
      @(negedge clock);
    end
    check(name, n, 1024);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: bench still running at cycle %0d, required completion", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    clear_model();
    repeat (3) tick();
    @(negedge clock);
    check("rst_upd_ready", upd_ready, 0);
    check("rst_qry_ready", qry_ready, 0);
    check("rst_resp_valid", qry_resp_valid, 0);
    check("rst_resp_data", qry_resp_data, 0);
    check("rst_clear_busy", clear_busy, 1);
    @(posedge clock);
    #1;
    reset = 1'b0;
    count_busy("init_sweep_len");
    check("run_clear_busy", clear_busy, 0);
    check("run_upd_ready", upd_ready, 1);
    tick();

    for (int i = 0; i < 17; i++) begin
      u4_valid = 1'b1;
      u4_index = '0;
      @(negedge clock);
      check("u4_ready", u4_ready, 1);
      tick();
    end
    u4_valid = 1'b0;
    q4_valid = 1'b1;
    q4_index = '0;
    @(negedge clock);
    check("q4_ready", q4_ready, 1);
    sb4.push_back('{32'(SAT_EXP), cyc + 2});
    tick();
    q4_valid = 1'b0;

    qry(5);
    for (int i = 0; i < 4; i++) upd(7);
    qry(7);
    upd(3); upd(9); upd(3); upd(9); upd(3);
    qry(3);
    qry(9);

    upd_valid = 1'b1; upd_index = IW'(11);
    qry_valid = 1'b1; qry_index = IW'(11);
    @(negedge clock);
    check("qry_ready_blocked", qry_ready, 0);
    model[11]++;
    tick();
    upd_valid = 1'b0;
    @(negedge clock);
    check("qry_ready_freed", qry_ready, 1);
    sb.push_back('{model[11], cyc + 2});
    tick();
    qry_valid = 1'b0;

    upd(20); tick(); upd(20); tick(); tick(); upd(20);
    qry(20);

    for (int i = 0; i < 10; i++) upd(2);
    clear_start = 1'b1;
    qry_valid = 1'b1; qry_index = IW'(2);
    @(negedge clock);
    check("qry_ready_at_clear", qry_ready, 1);
    sb.push_back('{model[2], cyc + 2});
    tick();
    clear_start = 1'b0;
    qry_valid = 1'b0;
    n = 0;
    @(negedge clock);
    while (!upd_ready && n < 3000) begin
      clear_start = (n == 100);
      n++;
      @(negedge clock);
    end
    clear_start = 1'b0;
    check("clear_upd_stall_len", n, 1024);
    clear_model();
    tick();
    qry(2);

    upd(30); upd(30);
    clear_start = 1'b1;
    tick();
    clear_start = 1'b0;
    repeat (512) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    count_busy("reset_sweep_len");
    clear_model();
    tick();
    qry(30);
    upd(7);
    qry(7);

    repeat (5) @(negedge clock);
    check("sb_drained", sb.size(), 0);
    check("sb4_drained", sb4.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/sketch_row_counter.md
# sketch_row_counter

Single row of the count-min sketch: consumes the 10-bit bucket index produced by the per-row flow hash, one per cycle, and increments the addressed counter in on-chip RAM via a pipelined read-modify-write with hazard forwarding. Also provides a low-priority query port for control-plane read-out and a full-row clear sweep. One instance sits downstream of each hash instance in the output-port-lookup sketch path.

## Interface
- `INDEX_WIDTH`, 10: bucket index width; row depth is 2^INDEX_WIDTH.
- `COUNT_WIDTH`, 32: counter width.
- `clock` in 1: sole clock.
- `reset` in 1: synchronous, active-high.
- `upd_valid` in 1: update request this cycle.
- `upd_index` in INDEX_WIDTH: bucket to increment.
- `upd_ready` out 1: update accepted when `upd_valid && upd_ready`.
- `qry_valid` in 1: query request.
- `qry_index` in INDEX_WIDTH: bucket to read.
- `qry_ready` out 1: query accepted when `qry_valid && qry_ready`.
- `qry_resp_valid` out 1: one-cycle pulse with result.
- `qry_resp_data` out COUNT_WIDTH: counter value.
- `clear_start` in 1: request a zeroing sweep.
- `clear_busy` out 1: sweep in progress.

## Operation
- FSM states: CLEAR, RUN.
  - `reset` enters CLEAR with the sweep address at 0.
  - CLEAR writes 0 to one address per cycle, ascending. After address 2^INDEX_WIDTH−1 is written, the next state is RUN.
  - In RUN, `clear_start` enters CLEAR at address 0 on the next cycle.
  - `clear_start` while already in CLEAR is ignored; the sweep does not restart.
- `upd_ready = (state==RUN)`. The update port never stalls in RUN, so full line rate is sustained.
- `qry_ready = (state==RUN) && !upd_valid`. Updates have strict priority over queries.
- Update pipeline:
  - S0 (accept cycle): issue the RAM read of `upd_index`.
  - S1 (next cycle): `new = src + 1`, written to RAM at the end of S1.
  - `src` is the last-write register value if its index matches the S1 index and it is valid; otherwise it is RAM read data.
  - The last-write register holds the index and value of the most recent S1 write.
- Query:
  - Reads the RAM in its accept cycle.
  - Next cycle applies the same forwarding as S1: it checks the in-flight S1 write first, then the last-write register.
  - The result is registered to the output.
- Arithmetic: `new` is COUNT_WIDTH bits. Overflow behaviour is set by the configuration macro.
- Reset mid-operation: in-flight S1 writes and pending query responses are discarded, the last-write register is invalidated, and the sweep restarts at address 0.
- Entering CLEAR from RUN: an update already in S1 still completes its write, then the sweep overwrites it. A query already accepted still responds.

## Timing
- Reset values:
  - `upd_ready`=0, `qry_ready`=0.
  - `qry_resp_valid`=0, `qry_resp_data`=0.
  - `clear_busy`=1.
- Sweep length: 2^INDEX_WIDTH cycles (1024 at default). `clear_busy` deasserts in the first RUN cycle.
- Update latency: a counter written at the end of cycle N+1 for an update accepted in cycle N.
- Query latency: `qry_resp_valid` high in cycle N+2 for a query accepted in cycle N. The result reflects every update accepted up to and including cycle N−1.
- Back-to-back updates to the same index: each sees the previous increment through forwarding. No increment is lost at any spacing.

## Configuration
- `SKETCH_SATURATE_EN` defined: a counter at 2^COUNT_WIDTH−1 stays at that value on increment.
- `SKETCH_SATURATE_EN` undefined: the counter wraps to 0 (modulo 2^COUNT_WIDTH).

## Structure
- Package `sketch_pkg` holds:
  - `SKETCH_INDEX_WIDTH` and `SKETCH_COUNT_WIDTH` constants;
  - `sketch_idx_t` and `sketch_cnt_t` typedefs;
  - the state enum `sketch_row_state_e`.
- Sub-module `sketch_row_ram`: simple dual-port RAM (one write port, one read port), synchronous read with 1-cycle latency, read-first on address collision. No reset on its contents; zeroing is done by the sweep.

## Test plan
- Reset, then 1024 idle cycles: `clear_busy` falls in cycle 1024 after reset release. A query to index 5 returns 0 two cycles after acceptance.
- Updates to index 7 on 4 consecutive cycles, then a query to 7: `qry_resp_data`=4.
- Alternating index sequence 3,9,3,9,3, then queries to 3 and 9: responses 3 and 2.
- `upd_valid` and `qry_valid` asserted together: `qry_ready`=0 that cycle; the query is accepted on the first cycle with `upd_valid`=0.
- COUNT_WIDTH=4, 17 updates to index 0:
  - with `SKETCH_SATURATE_EN` defined, a query returns 15;
  - without it, a query returns 1.
- Pulse `clear_start` after 10 updates to index 2: `upd_ready`=0 for 1024 cycles, and a subsequent query to 2 returns 0. Asserting `reset` halfway through the sweep restarts it, with `clear_busy` held for a full 1024 cycles.
